// File: rtl/ifid_skid_stagereg.sv
// IF/ID stage register with valid/ready handshakes on both sides and a
// 2-entry skid buffer (main + skid). in_ready depends only on registered
// occupancy, so there is no combinational path from out_ready or flush to fetch.
//
// Ports:
//   clk, nrst              clock; synchronous active-low reset
//   in_valid/in_ready      fetch-side handshake; in_inst, in_pc carry the payload
//   out_valid/out_ready    decode-side handshake; out_inst, out_pc carry the payload
//                          (NOP_INST and 0 while out_valid=0)
//   flush                  drop all held entries and any same-cycle accept
//   stall_cnt, flush_cnt   performance counters, present only with IFID_PERF_CNT_EN
module ifid_skid_stagereg #(
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       PC_W     = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  input  logic              flush
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [INST_W-1:0] main_inst_q, main_inst_d;
  logic [PC_W-1:0]   main_pc_q, main_pc_d;
  logic [INST_W-1:0] skid_inst_q, skid_inst_d;
  logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
  logic              acc;
  logic              pop;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign acc       = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_inst  = out_valid ? main_inst_q : NOP_INST;
  assign out_pc    = out_valid ? main_pc_q : '0;

  always_comb begin
    state_d     = state_q;
    main_inst_d = main_inst_q;
    main_pc_d   = main_pc_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;

    case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d     = ONE;
          main_inst_d = in_inst;
          main_pc_d   = in_pc;
        end
      end
      ONE: begin
        if (acc && pop) begin
          main_inst_d = in_inst;
          main_pc_d   = in_pc;
        end else if (acc) begin
          state_d     = FULL;
          skid_inst_d = in_inst;
          skid_pc_d   = in_pc;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the skid-to-main shift can happen.
        if (pop) begin
          state_d     = ONE;
          main_inst_d = skid_inst_q;
          main_pc_d   = skid_pc_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Data registers may still load on a flush; EMPTY masks them at the outputs.
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    main_inst_q <= main_inst_d;
    main_pc_q   <= main_pc_d;
    skid_inst_q <= skid_inst_d;
    skid_pc_q   <= skid_pc_d;
  end

`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !out_ready) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush && (state_q != EMPTY)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ifid_skid_stagereg.sv
module tb_ifid_skid_stagereg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        nrst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        flush;
`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  always #5 clk = ~clk;

  ifid_skid_stagereg #(
    .INST_W  (32),
    .PC_W    (32),
    .NOP_INST(32'h0000_0013)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_inst  (in_inst),
    .in_pc    (in_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst (out_inst),
    .out_pc   (out_pc),
    .flush    (flush)
`ifdef IFID_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  // One cycle of stimulus plus the outputs expected to be visible during it.
  typedef struct {
    logic        iv;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic        er;
    logic [31:0] epc;
  } vec_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  vec_t        vecs[$];
  ent_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;

  function automatic vec_t mk(input logic iv, input logic [31:0] pc, input logic ordy,
                              input logic fl, input logic ev, input logic er,
                              input logic [31:0] epc);
    vec_t v;
    v.iv   = iv;
    v.pc   = pc;
    v.inst = 32'h0050_0093 + (pc << 12);
    v.ordy = ordy;
    v.fl   = fl;
    v.ev   = ev;
    v.er   = er;
    v.epc  = epc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, ".out_inst"}, out_inst, NOP);
    chk({tag, ".out_pc"}, out_pc, 32'd0);
`ifdef IFID_PERF_CNT_EN
    chk({tag, ".stall_cnt"}, stall_cnt, 32'd0);
    chk({tag, ".flush_cnt"}, flush_cnt, 32'd0);
`endif
  endtask

  // Called at a falling edge: check outputs, update the scoreboard, drive inputs,
  // then advance to the next falling edge.
  task automatic step(input vec_t v, input string tag);
    ent_t e;
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v.ev});
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, v.er});
    chk({tag, ".out_pc"}, out_pc, v.epc);
    chk({tag, ".sb_occupancy"}, {31'd0, out_valid}, {31'd0, sb.size() != 0});
    if (!v.ev) chk({tag, ".nop"}, out_inst, NOP);
`ifdef IFID_PERF_CNT_EN
    chk({tag, ".stall_cnt"}, stall_cnt, exp_stall);
    chk({tag, ".flush_cnt"}, flush_cnt, exp_flush);
    if (v.ev && !v.ordy) exp_stall++;
    if (v.fl && v.ev) exp_flush++;
`endif
    if (v.ev && v.ordy) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s.pop actual=valid required=empty", tag);
      end else begin
        e = sb.pop_front();
        chk({tag, ".pop_inst"}, out_inst, e.inst);
        chk({tag, ".pop_pc"}, out_pc, e.pc);
      end
    end
    if (v.fl) sb.delete();
    else if (v.iv && v.er) sb.push_back('{v.inst, v.pc});
    in_valid  = v.iv;
    in_inst   = v.inst;
    in_pc     = v.pc;
    out_ready = v.ordy;
    flush     = v.fl;
    @(negedge clk);
  endtask

  initial begin
    //                  iv  pc     ordy fl  ev  er  epc
    vecs.push_back(mk(1, 0,  0, 0, 0, 1, 0));   // first input after reset
    vecs.push_back(mk(0, 0,  1, 0, 1, 1, 0));
    vecs.push_back(mk(1, 0,  1, 0, 0, 1, 0));   // streaming 0,4,8,12
    vecs.push_back(mk(1, 4,  1, 0, 1, 1, 0));
    vecs.push_back(mk(1, 8,  1, 0, 1, 1, 4));   // accept+pop in ONE
    vecs.push_back(mk(1, 12, 1, 0, 1, 1, 8));
    vecs.push_back(mk(0, 0,  1, 0, 1, 1, 12));
    vecs.push_back(mk(1, 0,  0, 0, 0, 1, 0));   // back-pressure
    vecs.push_back(mk(1, 4,  0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 8,  0, 0, 1, 0, 0));   // FULL, pc8 held
    vecs.push_back(mk(1, 8,  1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 8,  1, 0, 1, 1, 4));
    vecs.push_back(mk(0, 0,  1, 0, 1, 1, 8));
    vecs.push_back(mk(1, 20, 0, 0, 0, 1, 0));   // fill, then flush in FULL
    vecs.push_back(mk(1, 24, 0, 0, 1, 1, 20));
    vecs.push_back(mk(1, 16, 0, 1, 1, 0, 20));
    vecs.push_back(mk(0, 0,  1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 28, 0, 0, 0, 1, 0));   // flush in ONE with accept+pop
    vecs.push_back(mk(1, 32, 1, 1, 1, 1, 28));
    vecs.push_back(mk(0, 0,  1, 1, 0, 1, 0));   // flush while EMPTY
    vecs.push_back(mk(0, 0,  1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 40, 0, 0, 0, 1, 0));   // fill for mid-op reset
    vecs.push_back(mk(1, 44, 0, 0, 1, 1, 40));

    nrst      = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h0050_0093;
    in_pc     = 32'd0;
    out_ready = 1'b0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    nrst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("v%0d", i));
    end

    // Reset while FULL with out_ready high: entries dropped, nothing popped.
    chk("mid.pre_valid", {31'd0, out_valid}, 32'd1);
    nrst      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    nrst = 1'b1;
    sb.delete();
    exp_stall = 0;
    exp_flush = 0;
    chk_idle("midreset");
    step(mk(0, 0, 1, 0, 0, 1, 0), "mr0");

    // Three stalled cycles then a flush of a non-empty stage.
    step(mk(1, 48, 0, 0, 0, 1, 0), "pc0");
    step(mk(0, 0,  0, 0, 1, 1, 48), "pc1");
    step(mk(0, 0,  0, 0, 1, 1, 48), "pc2");
    step(mk(0, 0,  0, 0, 1, 1, 48), "pc3");
    step(mk(0, 0,  1, 1, 1, 1, 48), "pc4");
`ifdef IFID_PERF_CNT_EN
    chk("perf.stall3", stall_cnt, 32'd3);
    chk("perf.flush1", flush_cnt, 32'd1);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    chk_idle("perfreset");
`endif
    step(mk(0, 0, 1, 0, 0, 1, 0), "end");

    chk("sb.drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
